// File: rtl/hazard_unit_fwd_pkg.sv
// Shared types for the hazard/forwarding unit: FSM states, forwarding selects and a
// saturating-increment helper for the optional stall counters.
package hazard_unit_fwd_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    LU_BUBBLE = 2'b01,
    DMEM_WAIT = 2'b10,
    ERR       = 2'b11
  } hazard_state_t;

  // FWD_MA: EX/MA ALU result, FWD_WB: MA/WB result, FWD_WBD: WB write data.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MA  = 2'b01,
    FWD_WB  = 2'b10,
    FWD_WBD = 2'b11
  } fwd_sel_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic inc);
    return (inc && !(&value)) ? value + 32'd1 : value;
  endfunction

endpackage

// File: rtl/hazard_unit_fwd_if.sv
// Pipeline-side signal bundle of the hazard unit. With HAZARD_PERF_CNT_EN defined the
// bundle also carries the three stall-cycle counters.
interface hazard_unit_fwd_if #(
  parameter int unsigned REG_ADDR = 5,
  parameter int unsigned NUM_SRC  = 2
);
  logic                        i_instr_ready;
  logic                        i_data_ready;
  logic                        i_ma_mem_req;
  logic [NUM_SRC*REG_ADDR-1:0] i_id_src;
  logic [NUM_SRC-1:0]          i_id_src_used;
  logic [REG_ADDR-1:0]         i_ex_reg_dest;
  logic                        i_ex_reg_wr;
  logic                        i_ex_mem_rd;
  logic [REG_ADDR-1:0]         i_ma_reg_dest;
  logic                        i_ma_reg_wr;
  logic [REG_ADDR-1:0]         i_wb_reg_dest;
  logic                        i_wb_reg_wr;
  logic                        i_flush;
  logic                        o_if_clk_en;
  logic                        o_id_clk_en;
  logic                        o_ex_clk_en;
  logic                        o_ma_clk_en;
  logic [2*NUM_SRC-1:0]        o_fwd_sel;
  logic                        o_mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]                 o_lu_stalls;
  logic [31:0]                 o_dmem_stalls;
  logic [31:0]                 o_imem_stalls;
`endif

  modport master (
    output i_instr_ready, i_data_ready, i_ma_mem_req, i_id_src, i_id_src_used,
    output i_ex_reg_dest, i_ex_reg_wr, i_ex_mem_rd, i_ma_reg_dest, i_ma_reg_wr,
    output i_wb_reg_dest, i_wb_reg_wr, i_flush,
    input  o_if_clk_en, o_id_clk_en, o_ex_clk_en, o_ma_clk_en, o_fwd_sel, o_mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    , input o_lu_stalls, o_dmem_stalls, o_imem_stalls
`endif
  );

  modport slave (
    input  i_instr_ready, i_data_ready, i_ma_mem_req, i_id_src, i_id_src_used,
    input  i_ex_reg_dest, i_ex_reg_wr, i_ex_mem_rd, i_ma_reg_dest, i_ma_reg_wr,
    input  i_wb_reg_dest, i_wb_reg_wr, i_flush,
    output o_if_clk_en, o_id_clk_en, o_ex_clk_en, o_ma_clk_en, o_fwd_sel, o_mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    , output o_lu_stalls, o_dmem_stalls, o_imem_stalls
`endif
  );

endinterface

// File: rtl/hazard_unit_fwd_fwd_match.sv
// Per-source comparator: picks the nearest producer for one ID source operand and flags
// a load-use dependency on the instruction currently in EX.
module hazard_unit_fwd_fwd_match
  import hazard_unit_fwd_pkg::*;
#(
  parameter int unsigned REG_ADDR = 5
) (
  input  logic [REG_ADDR-1:0] src_i,
  input  logic                used_i,
  input  logic [REG_ADDR-1:0] ex_dest_i,
  input  logic                ex_wr_i,
  input  logic                ex_mem_rd_i,
  input  logic [REG_ADDR-1:0] ma_dest_i,
  input  logic                ma_wr_i,
  input  logic [REG_ADDR-1:0] wb_dest_i,
  input  logic                wb_wr_i,
  output fwd_sel_t            sel_o,
  output logic                load_use_o
);

  logic live, hit_ex, hit_ma, hit_wb;

  always_comb begin
    // x0 is hardwired to zero, so it never has a producer.
    live       = used_i && (src_i != '0);
    hit_ex     = live && ex_wr_i && (ex_dest_i == src_i);
    hit_ma     = live && ma_wr_i && (ma_dest_i == src_i);
    hit_wb     = live && wb_wr_i && (wb_dest_i == src_i);
    load_use_o = hit_ex && ex_mem_rd_i;
    sel_o      = FWD_RF;
    if (hit_ex && !ex_mem_rd_i) begin
      sel_o = FWD_MA;
    end else if (hit_ma) begin
      sel_o = FWD_WB;
    end else if (hit_wb) begin
      sel_o = FWD_WBD;
    end
  end

endmodule

// File: rtl/hazard_unit_fwd.sv
// Hazard unit: stage clock enables, load-use bubble, data-memory wait/timeout FSM and
// registered forwarding selects. HAZARD_PERF_CNT_EN adds saturating stall-cycle counters.
module hazard_unit_fwd
  import hazard_unit_fwd_pkg::*;
#(
  parameter int unsigned REG_ADDR    = 5,
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst_n,
  hazard_unit_fwd_if.slave  bus
);

  localparam int unsigned TO_CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  hazard_state_t        state_q, state_d;
  logic [TO_CNT_W-1:0]  cnt_q, cnt_d, cnt_base;
  logic [2*NUM_SRC-1:0] fwd_q, fwd_comb;
  logic [NUM_SRC-1:0]   lu_hit;
  logic [3:0]           en;  // {if, id, ex, ma}
  logic                 dmem_wait, load_use, lu_stall, dmem_stall, imem_stall;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fwd_sel_t sel;
    hazard_unit_fwd_fwd_match #(
      .REG_ADDR(REG_ADDR)
    ) u_match (
      .src_i      (bus.i_id_src[k*REG_ADDR +: REG_ADDR]),
      .used_i     (bus.i_id_src_used[k]),
      .ex_dest_i  (bus.i_ex_reg_dest),
      .ex_wr_i    (bus.i_ex_reg_wr),
      .ex_mem_rd_i(bus.i_ex_mem_rd),
      .ma_dest_i  (bus.i_ma_reg_dest),
      .ma_wr_i    (bus.i_ma_reg_wr),
      .wb_dest_i  (bus.i_wb_reg_dest),
      .wb_wr_i    (bus.i_wb_reg_wr),
      .sel_o      (sel),
      .load_use_o (lu_hit[k])
    );
    assign fwd_comb[2*k +: 2] = sel;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    en         = 4'b1111;
    lu_stall   = 1'b0;
    dmem_stall = 1'b0;
    imem_stall = 1'b0;
    dmem_wait  = bus.i_ma_mem_req && !bus.i_data_ready;
    // The bubble cycle must not re-detect the same dependency.
    load_use   = (|lu_hit) && (state_q != LU_BUBBLE);
    cnt_base   = (state_q == DMEM_WAIT) ? cnt_q : '0;
    if (state_q == ERR) begin
      en = 4'b0000;
    end else if (dmem_wait) begin
      en         = 4'b0000;
      dmem_stall = 1'b1;
      state_d    = DMEM_WAIT;
      if (MEM_TIMEOUT > 0) begin
        cnt_d = cnt_base + TO_CNT_W'(1);
        if (cnt_d == TO_CNT_W'(MEM_TIMEOUT)) begin
          state_d = ERR;
        end
      end
    end else if (bus.i_flush) begin
      state_d = RUN;
    end else if (load_use) begin
      en       = 4'b0011;
      lu_stall = 1'b1;
      state_d  = LU_BUBBLE;
    end else begin
      state_d = RUN;
      if (!bus.i_instr_ready) begin
        en         = 4'b0011;
        imem_stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      fwd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // A bubble or a flushed slot entering EX carries no operands.
      if (en[1]) begin
        fwd_q <= (bus.i_flush || lu_stall) ? '0 : fwd_comb;
      end
    end
  end

  assign bus.o_if_clk_en   = en[3];
  assign bus.o_id_clk_en   = en[2];
  assign bus.o_ex_clk_en   = en[1];
  assign bus.o_ma_clk_en   = en[0];
  assign bus.o_fwd_sel     = fwd_q;
  assign bus.o_mem_timeout = (state_q == ERR);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_cnt_q, dmem_cnt_q, imem_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_cnt_q   <= '0;
      dmem_cnt_q <= '0;
      imem_cnt_q <= '0;
    end else begin
      lu_cnt_q   <= sat_inc(lu_cnt_q, lu_stall);
      dmem_cnt_q <= sat_inc(dmem_cnt_q, dmem_stall);
      imem_cnt_q <= sat_inc(imem_cnt_q, imem_stall);
    end
  end

  assign bus.o_lu_stalls   = lu_cnt_q;
  assign bus.o_dmem_stalls = dmem_cnt_q;
  assign bus.o_imem_stalls = imem_cnt_q;
`else
  logic unused_stall;
  assign unused_stall = dmem_stall ^ imem_stall;
`endif

endmodule
